// File: rtl/sudoku_pkg.sv
// Shared types and helpers for the Sudoku input front-end.
package sudoku_pkg;

  localparam int unsigned N     = 9;
  localparam int unsigned CELLS = 81;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_WRITE,
    ST_HOLD,
    ST_SOLVE
  } state_e;

  // Flat board index: row-major, row*9+col.
  function automatic logic [6:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
    return 7'(row) * 7'd9 + 7'(col);
  endfunction

endpackage

// File: rtl/sudoku_cell_hit.sv
// Pixel-to-cell mapping for the on-screen board using a comparator chain.
module sudoku_cell_hit
  import sudoku_pkg::*;
#(
  parameter int unsigned X0   = 160,
  parameter int unsigned Y0   = 80,
  parameter int unsigned CELL = 36
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  output logic [3:0] row,
  output logic [3:0] col,
  output logic       hit
);

  logic [31:0] px_w;
  logic [31:0] py_w;

  assign px_w = 32'(px);
  assign py_w = 32'(py);

  // Largest cell boundary not exceeding the cursor gives row/col; hit bounds the grid.
  always_comb begin
    row = '0;
    col = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (px_w >= X0 + i * CELL) col = 4'(i);
      if (py_w >= Y0 + i * CELL) row = 4'(i);
    end
    hit = (px_w >= X0) && (px_w < X0 + N * CELL) &&
          (py_w >= Y0) && (py_w < Y0 + N * CELL);
  end

endmodule

// File: rtl/sudoku_input_ctrl.sv
// Sequences mouse selection, digit writes and solve requests into the solver.
module sudoku_input_ctrl
  import sudoku_pkg::*;
#(
  parameter int unsigned BOARD_X0 = 160,
  parameter int unsigned BOARD_Y0 = 80,
  parameter int unsigned CELL     = 36,
  parameter int unsigned GAP      = 4,
  parameter int unsigned TIMEOUT  = 100000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [9:0]   mouse_x,
  input  logic [9:0]   mouse_y,
  input  logic         mouse_left,
  input  logic         mouse_new_event,
  input  logic [3:0]   key_data,
  input  logic         key_enter,
  input  logic         solve_req,
  input  logic [80:0]  init_board_blank,
  input  logic         solver_valid,
  output logic         sel_valid,
  output logic [3:0]   sel_row,
  output logic [3:0]   sel_col,
  output logic [3:0]   wr_row,
  output logic [3:0]   wr_col,
  output logic [3:0]   wr_data,
  output logic         wr_pulse,
  output logic         start_pulse,
  output logic         busy,
  output logic         reject,
  output logic         solve_fail
);

  localparam int unsigned CNT_MAX = (TIMEOUT > GAP) ? TIMEOUT : GAP;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic            left_prev_q, left_prev_d;
  logic            sel_valid_q, sel_valid_d;
  logic [3:0]      sel_row_q, sel_row_d;
  logic [3:0]      sel_col_q, sel_col_d;
  logic [3:0]      wr_row_q, wr_row_d;
  logic [3:0]      wr_col_q, wr_col_d;
  logic [3:0]      wr_data_q, wr_data_d;
  logic            start_q, start_d;
  logic            reject_q, reject_d;
  logic            fail_q, fail_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            click;
  logic            go_solve;
  logic            hit;
  logic [3:0]      hit_row;
  logic [3:0]      hit_col;

  sudoku_cell_hit #(
    .X0  (BOARD_X0),
    .Y0  (BOARD_Y0),
    .CELL(CELL)
  ) u_hit (
    .px (mouse_x),
    .py (mouse_y),
    .row(hit_row),
    .col(hit_col),
    .hit(hit)
  );

  assign click = mouse_new_event & mouse_left & ~left_prev_q;

  // Next-state and command decode; solve_req outranks key_enter, which outranks clicks.
  always_comb begin
    state_d     = state_q;
    ret_d       = ret_q;
    left_prev_d = mouse_new_event ? mouse_left : left_prev_q;
    sel_valid_d = sel_valid_q;
    sel_row_d   = sel_row_q;
    sel_col_d   = sel_col_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    reject_d    = 1'b0;
    fail_d      = fail_q;
    cnt_d       = cnt_q;
    go_solve    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (solve_req) begin
          go_solve = 1'b1;
        end else if (key_enter) begin
          reject_d = 1'b1;
        end else if (click && hit) begin
          sel_valid_d = 1'b1;
          sel_row_d   = hit_row;
          sel_col_d   = hit_col;
          state_d     = ST_SEL;
        end
      end
      ST_SEL: begin
        if (solve_req) begin
          go_solve = 1'b1;
        end else if (key_enter) begin
          if ((key_data > 4'd9) || !init_board_blank[cell_idx(sel_row_q, sel_col_q)]) begin
            reject_d = 1'b1;
          end else begin
            wr_row_d  = sel_row_q;
            wr_col_d  = sel_col_q;
            wr_data_d = key_data;
            state_d   = ST_WRITE;
          end
        end else if (click) begin
          if (hit) begin
            sel_row_d = hit_row;
            sel_col_d = hit_col;
          end else begin
            sel_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_WRITE, ST_HOLD: begin
        reject_d = key_enter | solve_req;
        // Misses are ignored here so the cooldown always lands back in SEL with a valid cell.
        if (click && hit) begin
          sel_row_d = hit_row;
          sel_col_d = hit_col;
        end
        if (state_q == ST_WRITE) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == CW'(GAP - 1)) begin
          state_d = ST_SEL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SOLVE: begin
        reject_d = click | key_enter | solve_req;
        if (solver_valid) begin
          state_d = ret_q;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fail_d  = 1'b1;
          state_d = ret_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_solve) begin
      ret_d    = state_q;
      state_d  = ST_SOLVE;
      start_d  = 1'b1;
      cnt_d    = '0;
      fail_d   = 1'b0;
      reject_d = key_enter;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ret_q       <= ST_IDLE;
      left_prev_q <= 1'b0;
      sel_valid_q <= 1'b0;
      sel_row_q   <= '0;
      sel_col_q   <= '0;
      wr_row_q    <= '0;
      wr_col_q    <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      reject_q    <= 1'b0;
      fail_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      left_prev_q <= left_prev_d;
      sel_valid_q <= sel_valid_d;
      sel_row_q   <= sel_row_d;
      sel_col_q   <= sel_col_d;
      wr_row_q    <= wr_row_d;
      wr_col_q    <= wr_col_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      reject_q    <= reject_d;
      fail_q      <= fail_d;
      cnt_q       <= cnt_d;
    end
  end

  assign sel_valid   = sel_valid_q;
  assign sel_row     = sel_row_q;
  assign sel_col     = sel_col_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign wr_pulse    = (state_q == ST_WRITE);
  assign start_pulse = start_q;
  assign busy        = (state_q == ST_WRITE) || (state_q == ST_HOLD) || (state_q == ST_SOLVE);
  assign reject      = reject_q;
  assign solve_fail  = fail_q;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// Directed bench for sudoku_input_ctrl with a cycle-level behavioural model.
module tb_sudoku_input_ctrl;

  localparam int X0   = 160;
  localparam int Y0   = 80;
  localparam int CELL = 36;
  localparam int GAP  = 4;
  localparam int TO   = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  mouse_x = '0;
  logic [9:0]  mouse_y = '0;
  logic        mouse_left = 1'b0;
  logic        mouse_new_event = 1'b0;
  logic [3:0]  key_data = '0;
  logic        key_enter = 1'b0;
  logic        solve_req = 1'b0;
  logic [80:0] init_board_blank;
  logic        solver_valid = 1'b0;
  logic        sel_valid, wr_pulse, start_pulse, busy, reject, solve_fail;
  logic [3:0]  sel_row, sel_col, wr_row, wr_col, wr_data;

  int checks = 0;
  int errors = 0;

  sudoku_input_ctrl #(
    .BOARD_X0(X0),
    .BOARD_Y0(Y0),
    .CELL    (CELL),
    .GAP     (GAP),
    .TIMEOUT (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mouse_x         (mouse_x),
    .mouse_y         (mouse_y),
    .mouse_left      (mouse_left),
    .mouse_new_event (mouse_new_event),
    .key_data        (key_data),
    .key_enter       (key_enter),
    .solve_req       (solve_req),
    .init_board_blank(init_board_blank),
    .solver_valid    (solver_valid),
    .sel_valid       (sel_valid),
    .sel_row         (sel_row),
    .sel_col         (sel_col),
    .wr_row          (wr_row),
    .wr_col          (wr_col),
    .wr_data         (wr_data),
    .wr_pulse        (wr_pulse),
    .start_pulse     (start_pulse),
    .busy            (busy),
    .reject          (reject),
    .solve_fail      (solve_fail)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit model_hit(input int x, input int y, output int r, output int c);
    r = 0;
    c = 0;
    if (x < X0 || x >= X0 + 9 * CELL || y < Y0 || y >= Y0 + 9 * CELL) return 1'b0;
    c = (x - X0) / CELL;
    r = (y - Y0) / CELL;
    return 1'b1;
  endfunction

  bit m_prev, m_selv, m_fail, in_solve, e_wr, e_start, e_rej, m_click, m_hit;
  int m_row, m_col, m_wrr, m_wrc, m_wrd, write_age, solve_age, hr, hc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 0; m_selv = 0; m_fail = 0; in_solve = 0;
      m_row = 0; m_col = 0; m_wrr = 0; m_wrc = 0; m_wrd = 0;
      write_age = -1; solve_age = 0; e_start = 0; e_rej = 0;
    end else begin
      m_click = mouse_new_event && mouse_left && !m_prev;
      if (mouse_new_event) m_prev = mouse_left;
      m_hit = model_hit(int'(mouse_x), int'(mouse_y), hr, hc);
      e_rej = 0;
      e_start = 0;
      if (in_solve) begin
        e_rej = m_click || key_enter || solve_req;
        if (solver_valid) in_solve = 0;
        else if (solve_age == TO - 1) begin m_fail = 1; in_solve = 0; end
        else solve_age++;
      end else if (write_age >= 0) begin
        e_rej = key_enter || solve_req;
        if (m_click && m_hit) begin m_row = hr; m_col = hc; end
        write_age++;
        if (write_age == 1 + GAP) write_age = -1;
      end else if (solve_req) begin
        in_solve = 1; solve_age = 0; m_fail = 0; e_start = 1; e_rej = key_enter;
      end else if (key_enter) begin
        if (!m_selv || key_data > 9 || !init_board_blank[m_row * 9 + m_col]) e_rej = 1;
        else begin write_age = 0; m_wrr = m_row; m_wrc = m_col; m_wrd = key_data; end
      end else if (m_click) begin
        if (m_hit) begin m_selv = 1; m_row = hr; m_col = hc; end
        else m_selv = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      e_wr = (write_age == 0);
      chk("m_sel_valid", sel_valid, m_selv);
      chk("m_sel_row", sel_row, m_row);
      chk("m_sel_col", sel_col, m_col);
      chk("m_wr_row", wr_row, m_wrr);
      chk("m_wr_col", wr_col, m_wrc);
      chk("m_wr_data", wr_data, m_wrd);
      chk("m_wr_pulse", wr_pulse, e_wr);
      chk("m_start_pulse", start_pulse, e_start);
      chk("m_busy", busy, in_solve || write_age >= 0);
      chk("m_reject", reject, e_rej);
      chk("m_solve_fail", solve_fail, m_fail);
    end
  end

  // ---------------- stimulus ----------------
  task automatic click_at(input int x, input int y);
    @(negedge clk);
    mouse_x = 10'(x); mouse_y = 10'(y); mouse_left = 1; mouse_new_event = 1;
    @(negedge clk);
    mouse_left = 0;
    @(negedge clk);
    mouse_new_event = 0;
  endtask

  task automatic press_enter(input int d);
    @(negedge clk);
    key_data = 4'(d); key_enter = 1;
    @(negedge clk);
    key_enter = 0;
  endtask

  task automatic pulse_solve();
    @(negedge clk);
    solve_req = 1;
    @(negedge clk);
    solve_req = 0;
  endtask

  task automatic busy_len(input string name, input int exp);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk(name, n, exp);
  endtask

  initial begin
    int n;
    init_board_blank = '1;
    init_board_blank[0] = 1'b0;

    #1;
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    @(negedge clk);
    rst_n = 1;

    click_at(X0 + 2 * CELL + 5, Y0 + 7 * CELL + 1);
    chk("sel_r7c2_valid", sel_valid, 1);
    chk("sel_r7c2_row", sel_row, 7);
    chk("sel_r7c2_col", sel_col, 2);

    click_at(314, 198);
    press_enter(5);
    chk("wr_pulse", wr_pulse, 1);
    chk("wr_row3", wr_row, 3);
    chk("wr_col4", wr_col, 4);
    chk("wr_data5", wr_data, 5);
    busy_len("write_busy_len", 1 + GAP);

    press_enter(12);
    chk("rej_key12", reject, 1);
    chk("rej_key12_nowr", wr_pulse, 0);
    @(negedge clk);
    chk("rej_one_cycle", reject, 0);

    click_at(165, 85);
    press_enter(3);
    chk("rej_fixed_cell", reject, 1);

    click_at(100, 100);
    chk("miss_deselect", sel_valid, 0);
    press_enter(1);
    chk("rej_idle_enter", reject, 1);

    // click and enter together: the write uses the old selection
    click_at(314, 198);
    @(negedge clk);
    mouse_x = 10'(343); mouse_y = 10'(263); mouse_left = 1; mouse_new_event = 1;
    key_data = 7; key_enter = 1;
    @(negedge clk);
    key_enter = 0; mouse_left = 0;
    chk("simul_wr_row", wr_row, 3);
    chk("simul_wr_col", wr_col, 4);
    chk("simul_wr_data", wr_data, 7);
    @(negedge clk);
    mouse_new_event = 0;
    busy_len("simul_busy_len", GAP);
    chk("simul_keep_row", sel_row, 3);
    chk("simul_keep_col", sel_col, 4);

    pulse_solve();
    chk("solve_start", start_pulse, 1);
    repeat (49) @(negedge clk);
    chk("solve_busy49", busy, 1);
    solver_valid = 1;
    @(negedge clk);
    solver_valid = 0;
    chk("solve_done_busy", busy, 0);
    chk("solve_done_fail", solve_fail, 0);
    chk("solve_keep_sel", sel_valid, 1);

    @(negedge clk);
    key_data = 2; key_enter = 1; solve_req = 1;
    @(negedge clk);
    key_enter = 0; solve_req = 0;
    chk("both_start", start_pulse, 1);
    chk("both_reject", reject, 1);
    mouse_x = 10'(343); mouse_y = 10'(263); mouse_left = 1; mouse_new_event = 1;
    @(negedge clk);
    mouse_left = 0;
    chk("solve_click_rej", reject, 1);
    chk("solve_click_row", sel_row, 3);
    @(negedge clk);
    mouse_new_event = 0;
    solver_valid = 1;
    @(negedge clk);
    solver_valid = 0;
    chk("solve2_done", busy, 0);

    pulse_solve();
    busy_len("timeout_len", TO);
    chk("timeout_fail", solve_fail, 1);

    press_enter(0);
    chk("clear_wr", wr_pulse, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_sel_valid", sel_valid, 0);
    chk("arst_fail", solve_fail, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_sel_row", sel_row, 0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (wr_pulse || start_pulse || reject) n++;
    end
    chk("quiet_after_rst", n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
